// File: rtl/fp64_cvt_to_d_pkg.sv
// Shared definitions for the int32/uint32/fp32 -> fp64 converter:
// operand selects, exponent constants, canonical NaN and FSM/kind encodings.
package fp64_cvt_to_d_pkg;

  // in_sel encodings (2'd3 is reserved)
  localparam logic [1:0] CVT_SEL_W  = 2'd0;
  localparam logic [1:0] CVT_SEL_WU = 2'd1;
  localparam logic [1:0] CVT_SEL_S  = 2'd2;

  localparam logic [10:0] FP64_BIAS          = 11'd1023;
  localparam logic [10:0] FP32_TO_FP64_EBIAS = 11'd896;
  // Integer loaded as mant * 2^(1054 - 1023 - 31): unnormalized exponent for bit 31
  localparam logic [10:0] INT_EXP_INIT       = 11'd1054;
  // fp32 subnormals have effective exponent 1 - 127 = -126 -> 897 in fp64 bias
  localparam logic [10:0] FP32_SUBN_EXP      = 11'd897;

  localparam logic [63:0] CVT_CANON_NAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StDone = 2'd2
  } cvt_state_e;

  typedef enum logic [2:0] {
    KindZero = 3'd0,
    KindNum  = 3'd1,
    KindInf  = 3'd2,
    KindNan  = 3'd3,
    KindRsvd = 3'd4
  } cvt_kind_e;

endpackage

// File: rtl/fp64_cvt_to_d_lzc32.sv
// 32-bit leading-zero counter (combinational). Returns 32 for an all-zero input.
module fp64_cvt_to_d_lzc32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_cnt
);

  logic w_found;

  // Scan from the MSB and stop counting at the first set bit
  always_comb begin
    o_cnt   = 6'd32;
    w_found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_cnt   = 6'(31 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp64_cvt_to_d.sv
// Multi-cycle exact converter into fp64: int32 (W), uint32 (WU) and fp32 (S).
// Optional macro FP64_CVT_FAST_NORM_EN replaces the one-bit-per-cycle normalizer
// with a single-cycle leading-zero count plus barrel shift.
module fp64_cvt_to_d
  import fp64_cvt_to_d_pkg::*;
#(
  parameter logic [63:0] CANON_NAN = CVT_CANON_NAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [1:0]  i_in_sel,
  input  logic [31:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_data,
  output logic        o_out_nv
);

  cvt_state_e  r_state, w_state_d;
  cvt_kind_e   r_kind, w_ld_kind;
  logic        r_sign, w_ld_sign;
  logic [31:0] r_mant, w_ld_mant, w_norm_mant;
  logic [10:0] r_exp, w_ld_exp, w_norm_exp;
  logic        r_nv, w_ld_nv;
  logic        r_out_valid, r_out_nv;
  logic [63:0] r_out_data, w_result;
  logic        w_accept, w_norm_done;
  logic [7:0]  w_e32;
  logic [22:0] w_frac;

  assign o_in_ready  = (r_state == StIdle) && !i_flush;
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_nv    = r_out_nv;
  assign w_e32       = i_in_data[30:23];
  assign w_frac      = i_in_data[22:0];

  // Decode the incoming operand into sign / unnormalized mantissa / exponent / kind
  always_comb begin
    w_ld_sign = 1'b0;
    w_ld_mant = 32'd0;
    w_ld_exp  = INT_EXP_INIT;
    w_ld_kind = KindNum;
    w_ld_nv   = 1'b0;
    case (i_in_sel)
      CVT_SEL_W: begin
        w_ld_sign = i_in_data[31];
        // Two's-complement negate; 0x8000_0000 maps onto itself, which is the right magnitude
        w_ld_mant = i_in_data[31] ? (~i_in_data + 32'd1) : i_in_data;
        if (i_in_data == 32'd0) w_ld_kind = KindZero;
      end
      CVT_SEL_WU: begin
        w_ld_mant = i_in_data;
        if (i_in_data == 32'd0) w_ld_kind = KindZero;
      end
      CVT_SEL_S: begin
        w_ld_sign = i_in_data[31];
        if (w_e32 == 8'hFF) begin
          w_ld_kind = (w_frac == 23'd0) ? KindInf : KindNan;
          w_ld_nv   = (w_frac != 23'd0) && !i_in_data[22];
        end else if (w_e32 == 8'd0) begin
          if (w_frac == 23'd0) begin
            w_ld_kind = KindZero;
          end else begin
            w_ld_mant = {1'b0, w_frac, 8'd0};
            w_ld_exp  = FP32_SUBN_EXP;
          end
        end else begin
          w_ld_mant = {1'b1, w_frac, 8'd0};
          w_ld_exp  = {3'd0, w_e32} + FP32_TO_FP64_EBIAS;
        end
      end
      default: w_ld_kind = KindRsvd;
    endcase
  end

`ifdef FP64_CVT_FAST_NORM_EN
  logic [5:0] w_lzc;

  fp64_cvt_to_d_lzc32 u_lzc (
    .i_data (r_mant),
    .o_cnt  (w_lzc)
  );

  // Whole normalization in one step; non-numbers pass through untouched
  always_comb begin
    w_norm_done = 1'b1;
    w_norm_mant = r_mant;
    w_norm_exp  = r_exp;
    if (r_kind == KindNum) begin
      w_norm_mant = r_mant << w_lzc;
      w_norm_exp  = r_exp - 11'(w_lzc);
    end
  end
`else
  // One-bit-per-cycle normalization step
  always_comb begin
    w_norm_done = (r_kind != KindNum) || r_mant[31];
    w_norm_mant = r_mant;
    w_norm_exp  = r_exp;
    if (!w_norm_done) begin
      w_norm_mant = r_mant << 1;
      w_norm_exp  = r_exp - 11'd1;
    end
  end
`endif

  // Pack the final fp64 result from the normalized registers
  always_comb begin
    w_result = 64'd0;
    unique case (r_kind)
      KindNum:  w_result = {r_sign, r_exp, r_mant[30:0], 21'd0};
      KindZero: w_result = {r_sign, 63'd0};
      KindInf:  w_result = {r_sign, 11'h7FF, 52'd0};
      KindNan:  w_result = CANON_NAN;
      default:  w_result = 64'd0;
    endcase
  end

  // FSM next state; flush beats both accept and the output handshake
  always_comb begin
    w_state_d = r_state;
    if (i_flush) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_accept) w_state_d = StNorm;
        StNorm:  if (w_norm_done) w_state_d = StDone;
        StDone:  if (r_out_valid && i_out_ready) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Operand/normalizer registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_mant      <= 32'd0;
      r_exp       <= 11'd0;
      r_kind      <= KindZero;
      r_nv        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 64'd0;
      r_out_nv    <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign <= w_ld_sign;
            r_mant <= w_ld_mant;
            r_exp  <= w_ld_exp;
            r_kind <= w_ld_kind;
            r_nv   <= w_ld_nv;
          end
        end
        StNorm: begin
          r_mant <= w_norm_mant;
          r_exp  <= w_norm_exp;
        end
        StDone: begin
          // First DONE cycle captures the result; afterwards hold until consumed
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_nv    <= r_nv;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_cvt_to_d.sv
// Self-checking bench for fp64_cvt_to_d: directed vectors, randomized operands
// against a real-arithmetic reference model, backpressure, flush and async reset.
module tb_fp64_cvt_to_d;

  localparam logic [63:0] NAN64 = 64'h7FF8_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [1:0]  i_in_sel;
  logic [31:0] i_in_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_out_data;
  logic        o_out_nv;

  int checks = 0;
  int failures = 0;

  fp64_cvt_to_d dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_sel    (i_in_sel),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_nv    (o_out_nv)
  );

  always #5 clk = ~clk;

  function automatic int msb_pos(input logic [31:0] v);
    int p = -1;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    return p;
  endfunction

  // Reference: value computed with real arithmetic, latency from the loaded-mantissa lead zeros
  function automatic void ref_cvt(input logic [1:0] sel, input logic [31:0] d,
                                  output logic [63:0] r, output logic nv, output int lat);
    real v;
    int  e, frac, lz;
    logic [31:0] mag;
    r = 64'd0; nv = 1'b0; lz = 0;
    if (sel == 2'd0 || sel == 2'd1) begin
      if (sel == 2'd0) v = real'(longint'($signed(d)));
      else             v = real'(longint'(d));
      if (d != 32'd0) begin
        r   = $realtobits(v);
        mag = (sel == 2'd0 && d[31]) ? (32'd0 - d) : d;
        lz  = 31 - msb_pos(mag);
      end
    end else if (sel == 2'd2) begin
      e    = int'(d[30:23]);
      frac = int'(d[22:0]);
      if (e == 255) begin
        if (frac == 0) r = {d[31], 11'h7FF, 52'd0};
        else begin r = NAN64; nv = !d[22]; end
      end else if (e == 0 && frac == 0) begin
        r = {d[31], 63'd0};
      end else begin
        if (e == 0) begin
          v  = real'(frac) * (2.0 ** real'(-149));
          lz = 31 - (msb_pos(32'(frac)) + 8);
        end else begin
          v = (real'(frac) + 8388608.0) * (2.0 ** real'(e - 150));
        end
        if (d[31]) v = -v;
        r = $realtobits(v);
      end
    end
`ifdef FP64_CVT_FAST_NORM_EN
    lat = 2;
`else
    lat = 2 + lz;
`endif
  endfunction

  // Issue one request, measure latency (edges after accept), take the result, handshake
  task automatic run_op(input logic [1:0] sel, input logic [31:0] d,
                        output logic [63:0] dat, output logic nv, output int lat);
    @(negedge clk);
    i_in_valid = 1'b1; i_in_sel = sel; i_in_data = d;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (o_out_valid) begin lat = c; break; end
    end
    dat = o_out_data; nv = o_out_nv;
    @(negedge clk); i_out_ready = 1'b1;
    @(posedge clk); #1; i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_in_sel = 2'd0; i_in_data = 32'd0;
    #23;
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_out_valid); end
    checks++; if (o_out_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_out_data); end
    checks++; if (o_out_nv !== 1'b0) begin failures++; $display("FAIL reset_nv got=%b exp=0", o_out_nv); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_in_ready); end
  endtask

  task automatic test_directed();
    logic [1:0]  sel_t [10] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    logic [31:0] in_t  [10] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0,
                                32'h3F80_0000, 32'h0000_0001, 32'hFF80_0000, 32'h7F80_0001,
                                32'h7FC0_0000, 32'h0001_2345};
    logic [63:0] exp_t [10] = '{64'hBFF0_0000_0000_0000, 64'hC1E0_0000_0000_0000,
                                64'h41E0_0000_0000_0000, 64'h0, 64'h3FF0_0000_0000_0000,
                                64'h36A0_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                                64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h0};
    logic        nv_t  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          lat_t [10] = '{33, 2, 2, 2, 2, 25, 2, 2, 2, 2};
    logic [63:0] dat;
    logic        nv;
    int          lat, elat;
    for (int i = 0; i < 10; i++) begin
      run_op(sel_t[i], in_t[i], dat, nv, lat);
`ifdef FP64_CVT_FAST_NORM_EN
      elat = 2;
`else
      elat = lat_t[i];
`endif
      checks++; if (dat !== exp_t[i]) begin failures++; $display("FAIL dir_data[%0d] got=%h exp=%h", i, dat, exp_t[i]); end
      checks++; if (nv !== nv_t[i]) begin failures++; $display("FAIL dir_nv[%0d] got=%b exp=%b", i, nv, nv_t[i]); end
      checks++; if (lat != elat) begin failures++; $display("FAIL dir_lat[%0d] got=%0d exp=%0d", i, lat, elat); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  sel;
    logic [31:0] d;
    logic [63:0] dat, edat;
    logic        nv, env;
    int          lat, elat;
    for (int i = 0; i < 60; i++) begin
      sel = 2'($urandom_range(0, 3));
      d   = $urandom;
      case ($urandom_range(0, 5))
        0: d = d >> $urandom_range(0, 31);       // small magnitudes, many leading zeros
        1: if (sel == 2'd2) d[30:23] = 8'h00;    // fp32 subnormal / zero
        2: if (sel == 2'd2) d[30:23] = 8'hFF;    // fp32 inf / nan
        default: ;
      endcase
      ref_cvt(sel, d, edat, env, elat);
      run_op(sel, d, dat, nv, lat);
      checks++; if (dat !== edat) begin failures++; $display("FAIL rnd_data sel=%0d in=%h got=%h exp=%h", sel, d, dat, edat); end
      checks++; if (nv !== env) begin failures++; $display("FAIL rnd_nv sel=%0d in=%h got=%b exp=%b", sel, d, nv, env); end
      checks++; if (lat != elat) begin failures++; $display("FAIL rnd_lat sel=%0d in=%h got=%0d exp=%0d", sel, d, lat, elat); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] dat, edat;
    logic        nv, env;
    int          lat, elat;
    bit          seen = 0;
    @(negedge clk);
    i_in_valid = 1'b1; i_in_sel = 2'd2; i_in_data = 32'h7F80_0001;
    @(posedge clk); #1; i_in_valid = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin @(posedge clk); #1; seen = o_out_valid; end
    checks++; if (!seen) begin failures++; $display("FAIL bp_timeout got=no_valid exp=valid"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (o_out_valid !== 1'b1 || o_out_data !== NAN64 || o_out_nv !== 1'b1 || o_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold v=%b d=%h nv=%b rdy=%b exp v=1 d=%h nv=1 rdy=0",
                 o_out_valid, o_out_data, o_out_nv, o_in_ready, NAN64);
      end
    end
    @(negedge clk); i_out_ready = 1'b1;
    @(posedge clk); #1; i_out_ready = 1'b0;
    checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release v=%b rdy=%b exp v=0 rdy=1", o_out_valid, o_in_ready);
    end
    ref_cvt(2'd1, 32'd5, edat, env, elat);
    run_op(2'd1, 32'd5, dat, nv, lat);
    checks++; if (dat !== edat || lat != elat) begin
      failures++; $display("FAIL bp_b2b got=%h/%0d exp=%h/%0d", dat, lat, edat, elat);
    end
  endtask

  task automatic test_flush();
    logic [63:0] dat, edat;
    logic        nv, env;
    int          lat, elat;
    bit          seen = 0;
    @(negedge clk);
    i_in_valid = 1'b1; i_in_sel = 2'd0; i_in_data = 32'd1;
    @(posedge clk); #1; i_in_valid = 1'b0;
    @(negedge clk); i_flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_during v=%b rdy=%b exp v=0 rdy=0", o_out_valid, o_in_ready);
    end
    @(negedge clk); i_flush = 1'b0; #1;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", o_in_ready); end
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (o_out_valid) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL flush_no_valid got=valid exp=none"); end
    ref_cvt(2'd0, 32'hFFFF_FFF9, edat, env, elat);
    run_op(2'd0, 32'hFFFF_FFF9, dat, nv, lat);
    checks++; if (dat !== edat || nv !== env || lat != elat) begin
      failures++; $display("FAIL flush_next got=%h/%b/%0d exp=%h/%b/%0d", dat, nv, lat, edat, env, elat);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] dat, edat;
    logic        nv, env;
    int          lat, elat;
    bit          seen = 0;
    // Mid-NORM reset abandons the operation
    @(negedge clk);
    i_in_valid = 1'b1; i_in_sel = 2'd0; i_in_data = 32'd1;
    @(posedge clk); #1; i_in_valid = 1'b0;
    @(posedge clk); #3; rst_n = 1'b0; #1;
    checks++; if (o_out_valid !== 1'b0 || o_out_data !== 64'd0) begin
      failures++; $display("FAIL rst_norm v=%b d=%h exp v=0 d=0", o_out_valid, o_out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (o_out_valid) seen = 1; end
    checks++; if (seen || o_in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_norm_after seen=%0d rdy=%b exp seen=0 rdy=1", seen, o_in_ready);
    end
    // Reset while the result is presented drops out_valid without a clock edge
    seen = 0;
    @(negedge clk);
    i_in_valid = 1'b1; i_in_sel = 2'd2; i_in_data = 32'h3F80_0000;
    @(posedge clk); #1; i_in_valid = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin @(posedge clk); #1; seen = o_out_valid; end
    checks++; if (!seen) begin failures++; $display("FAIL rst_done_timeout got=no_valid exp=valid"); end
    #2; rst_n = 1'b0; #1;
    checks++; if (o_out_valid !== 1'b0 || o_out_data !== 64'd0 || o_out_nv !== 1'b0) begin
      failures++; $display("FAIL rst_async v=%b d=%h nv=%b exp all 0", o_out_valid, o_out_data, o_out_nv);
    end
    @(negedge clk); rst_n = 1'b1;
    ref_cvt(2'd2, 32'hC2F6_E979, edat, env, elat);
    run_op(2'd2, 32'hC2F6_E979, dat, nv, lat);
    checks++; if (dat !== edat || lat != elat) begin
      failures++; $display("FAIL rst_next got=%h/%0d exp=%h/%0d", dat, lat, edat, elat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp64_cvt_to_d.md
Name: fp64_cvt_to_d

Overview:
- Multi-cycle converter into FP64 for the FPU datapath.
- Performs the opposite direction of the FP64 ALU's fp-to-int and d-to-s paths.
- Supported conversions:
  - int32 to fp64 (FCVT.D.W)
  - uint32 to fp64 (FCVT.D.WU)
  - fp32 to fp64 (FCVT.D.S)
- All conversions are exact, so no rounding logic is needed.
- Valid/ready handshake on the input and output sides.
- Iterative one-bit-per-cycle normalizer, so latency depends on the data.

Parameters:
- CANON_NAN, 64'h7FF8_0000_0000_0000: value returned for any fp32 NaN input.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; drops the operation in flight
- in_valid  in  1  a request is present
- in_ready  out  1  converter can accept a request (state==IDLE and !flush)
- in_sel  in  2  0=W (signed), 1=WU (unsigned), 2=S (fp32), 3=reserved
- in_data  in  32  integer or fp32 operand
- out_valid  out  1  out_data/out_nv are valid
- out_ready  in  1  consumer accepts the result
- out_data  out  64  fp64 result
- out_nv  out  1  invalid-operation flag; set only for an fp32 signalling-NaN input

Behaviour:
- Reset:
  - state=IDLE
  - out_valid=0, out_data=0, out_nv=0
  - internal mant/exp/sign registers cleared
  - in_ready=1 after reset is released
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - Accept when in_valid & in_ready, then go to NORM.
  - Loaded registers: sign, 32-bit mant, 11-bit exp, kind (zero/num/inf/nan/rsvd), nv.
- Load rules:
  - W: sign=in_data[31]; mant=|in_data| (0x8000_0000 stays 0x8000_0000); exp=1054.
  - WU: sign=0; mant=in_data; exp=1054.
  - S, normal (e32 in 1..254): mant={1,frac23,8'b0}; exp=e32+896.
  - S, subnormal: mant={0,frac23,8'b0}; exp=897.
  - S, zero: kind=zero, sign kept.
  - S, e32=255 with frac=0: kind=inf.
  - S, e32=255 with frac!=0: kind=nan; nv=!in_data[22].
  - Integer with mant==0: kind=zero, sign=0.
  - sel=3: kind=rsvd.
- NORM:
  - If kind!=num or mant[31]==1, go to DONE.
  - Otherwise mant<<=1 and exp-=1, staying in NORM.
  - exp never underflows: its minimum reachable value is 874.
- DONE:
  - out_valid=1 and out_data is registered.
  - num: {sign, exp, mant[30:0], 21'b0}
  - zero: {sign, 63'b0}
  - inf: {sign, 11'h7FF, 52'b0}
  - nan: CANON_NAN
  - rsvd: 64'b0, nv=0
  - out_data and out_nv stay stable while out_valid & !out_ready.
  - On out_ready, go to IDLE and clear out_valid.
  - A new request may be accepted on the cycle after the output handshake.
- Latency:
  - Measured from the accept edge to out_valid high: 2+L cycles.
  - L = number of leading zeros of the loaded mant (0..31); L=0 for zero, inf, nan and rsvd.
  - Worst case is 33 cycles.
- Single outstanding operation: in_ready=0 in NORM and DONE.
- flush:
  - Asserted in any state, it forces IDLE and out_valid=0 on the next edge.
  - Flush has priority over accept and over the output handshake.
  - in_ready=0 while flush=1.
- Asynchronous reset mid-operation abandons the result immediately.
- out_data is don't-care while out_valid=0; it holds its last value.

Optional Feature:
- Macro: FP64_CVT_FAST_NORM_EN.
- When defined:
  - NORM normalizes in one cycle using a 32-bit leading-zero counter and barrel shift, giving exp-=lzc.
  - Latency is fixed at 2 cycles.
  - All results are bit-identical to the iterative build.
- When undefined: the iterative one-bit-per-cycle normalizer described above is used.

Decomposition:
- Shared header/package (fp_cvt.vh):
  - in_sel encodings CVT_SEL_W, CVT_SEL_WU, CVT_SEL_S
  - FP64_BIAS=1023, FP32_TO_FP64_EBIAS=896, INT_EXP_INIT=1054
  - canonical NaN constant
  - FSM state encodings
- Sub-module: lzc32 (32-bit leading-zero counter, combinational).
  - Instantiated only under FP64_CVT_FAST_NORM_EN.

Test Plan:
- W, 0xFFFFFFFF (-1) accepted at T -> out_data=0xBFF0_0000_0000_0000 at T+33, out_nv=0 (fast build: T+2).
- W 0x80000000 -> 0xC1E0_0000_0000_0000 at T+2; WU 0x80000000 -> 0x41E0_0000_0000_0000 at T+2; W 0 -> 0x0 at T+2.
- S 0x3F800000 -> 0x3FF0_0000_0000_0000 at T+2; S 0x00000001 -> 0x36A0_0000_0000_0000 at T+25; S 0xFF800000 -> 0xFFF0_0000_0000_0000.
- S 0x7F800001 (sNaN) -> 0x7FF8_0000_0000_0000 with out_nv=1; S 0x7FC00000 (qNaN) -> same data with out_nv=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Required: data and nv stable, in_ready=0.
  - Then raise out_ready: in_ready=1 on the next cycle, and a back-to-back request is accepted.
- Flush and reset:
  - Pulse flush during NORM of W 0x00000001: no out_valid, in_ready=1 on the next cycle, the following request converts correctly.
  - Assert rst_n=0 mid-NORM: out_valid drops asynchronously.
